// File: rtl/vga_axil_csr.sv
// Purpose : AXI4-Lite responder holding the VGA control/status register bank.
// Latency : write commit and bvalid 1 cycle after the final AW/W handshake; rvalid 1 cycle after AR.
// Backpr. : one outstanding transaction per channel; readies stay low until B/R handshakes complete.
//
// Ports:
//   clk, arst_n           clock (rising edge) and asynchronous active-low reset
//   aw*/w*/b*             AXI4-Lite write address, data and response channels
//   ar*/r*                AXI4-Lite read address and data channels
//   regs_o                flat register contents, reg i at [i*AXIL_DATA_W +: AXIL_DATA_W]
//   wr_pulse_o            one-cycle pulse per register, aligned with the new value appearing
module vga_axil_csr #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int NUM_REGS    = 8
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [AXIL_ADDR_W-1:0]          awaddr,
  input  logic                            awvalid,
  output logic                            awready,
  input  logic [AXIL_DATA_W-1:0]          wdata,
  input  logic [AXIL_DATA_W/8-1:0]        wstrb,
  input  logic                            wvalid,
  output logic                            wready,
  output logic [1:0]                      bresp,
  output logic                            bvalid,
  input  logic                            bready,
  input  logic [AXIL_ADDR_W-1:0]          araddr,
  input  logic                            arvalid,
  output logic                            arready,
  output logic [AXIL_DATA_W-1:0]          rdata,
  output logic [1:0]                      rresp,
  output logic                            rvalid,
  input  logic                            rready,
  output logic [NUM_REGS*AXIL_DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]             wr_pulse_o
);

  localparam int STRB_W = AXIL_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [AXIL_ADDR_W-1:0] MAP_LIMIT = AXIL_ADDR_W'(NUM_REGS * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  logic [AXIL_DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_wr_pulse;

  logic [1:0]             r_wstate;
  logic                   r_awready;
  logic                   r_wready;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;
  logic [AXIL_ADDR_W-1:0] r_awaddr;
  logic [AXIL_DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0]      r_wstrb;

  logic [0:0]             r_rstate;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [AXIL_DATA_W-1:0] r_rdata;
  logic [1:0]             r_rresp;

  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_commit;
  logic [AXIL_ADDR_W-1:0] w_caddr;
  logic [AXIL_DATA_W-1:0] w_cdata;
  logic [STRB_W-1:0]      w_cstrb;
  logic                   w_cmapped;
  logic [IDX_W-1:0]       w_cidx;
  logic                   w_ar_hs;
  logic                   w_rmapped;
  logic [IDX_W-1:0]       w_ridx;

  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid & r_wready;

  // The final handshake may come from either channel; whichever half arrived
  // earlier is taken from its latch, the other straight from the bus.
  assign w_commit = ((r_wstate == W_IDLE)    & w_aw_hs & w_w_hs) |
                    ((r_wstate == W_HAVE_AW) & w_w_hs) |
                    ((r_wstate == W_HAVE_W)  & w_aw_hs);
  assign w_caddr   = (r_wstate == W_HAVE_AW) ? r_awaddr : awaddr;
  assign w_cdata   = (r_wstate == W_HAVE_W)  ? r_wdata  : wdata;
  assign w_cstrb   = (r_wstate == W_HAVE_W)  ? r_wstrb  : wstrb;
  assign w_cmapped = (w_caddr < MAP_LIMIT);
  assign w_cidx    = w_caddr[OFF_W +: IDX_W];

  assign w_ar_hs   = arvalid & r_arready;
  assign w_rmapped = (araddr < MAP_LIMIT);
  assign w_ridx    = araddr[OFF_W +: IDX_W];

  // Write channel FSM
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          // Readies come up here on the first edge out of reset.
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (!w_commit) begin
            if (w_aw_hs) begin
              r_awaddr  <= awaddr;
              r_awready <= 1'b0;
              r_wstate  <= W_HAVE_AW;
            end else if (w_w_hs) begin
              r_wdata  <= wdata;
              r_wstrb  <= wstrb;
              r_wready <= 1'b0;
              r_wstate <= W_HAVE_W;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: ;
      endcase
      if (w_commit) begin
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_cmapped ? RESP_OKAY : RESP_SLVERR;
        r_wstate  <= W_RESP;
      end
    end
  end

  // Register bank; unmapped commits leave everything untouched. A zero strobe
  // still counts as a commit and fires the pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_cmapped) begin
        r_wr_pulse[w_cidx] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (w_cstrb[b]) begin
            r_regs[w_cidx][b*8 +: 8] <= w_cdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read channel FSM; sampling r_regs here returns the pre-write value when a
  // write commits to the same register on the same edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (r_rstate == R_IDLE) begin
      r_arready <= 1'b1;
      if (w_ar_hs) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rmapped ? r_regs[w_ridx] : '0;
        r_rresp   <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
        r_rstate  <= R_RESP;
      end
    end else begin
      if (rready) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
        r_rstate  <= R_IDLE;
      end
    end
  end

  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bvalid     = r_bvalid;
  assign bresp      = r_bresp;
  assign arready    = r_arready;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign rresp      = r_rresp;
  assign wr_pulse_o = r_wr_pulse;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
    assign regs_o[gi*AXIL_DATA_W +: AXIL_DATA_W] = r_regs[gi];
  end

endmodule
